// File: rtl/store_buffer.sv
// In-order store buffer: rename allocates, execute resolves, ROB commits, memory drains.
// Define SB_FWD_EN to add the store-to-load forwarding search (ld_*/fwd_* ports).

module store_buffer_chk (
    input logic clk_i,
    input logic reset_n_i,
    input logic exe_bad,
    input logic commit_bad
);
    a_exe_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i) !exe_bad);
    a_commit_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i) !commit_bad);
endmodule

module store_buffer #(
    parameter int SB_ENTRY    = 8,
    parameter int WORD_SIZE_P = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        alloc_valid_i,
    output logic                        alloc_ready_o,
    output logic [$clog2(SB_ENTRY)-1:0] alloc_idx_o,
    input  logic                        exe_valid_i,
    input  logic [$clog2(SB_ENTRY)-1:0] exe_idx_i,
    input  logic [WORD_SIZE_P-1:0]      exe_addr_i,
    input  logic [WORD_SIZE_P-1:0]      exe_data_i,
    input  logic                        rob_sb_valid_i,
    input  logic                        rob_mispredict_i,
    output logic                        mem_valid_o,
    output logic [WORD_SIZE_P-1:0]      mem_addr_o,
    output logic [WORD_SIZE_P-1:0]      mem_data_o,
    input  logic                        mem_ready_i,
`ifdef SB_FWD_EN
    input  logic                        ld_valid_i,
    input  logic [WORD_SIZE_P-1:0]      ld_addr_i,
    output logic                        fwd_hit_o,
    output logic [WORD_SIZE_P-1:0]      fwd_data_o,
    output logic                        fwd_stall_o,
`endif
    output logic                        empty_o
);
    localparam int IW = $clog2(SB_ENTRY);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {
        ST_FREE      = 2'd0,
        ST_ALLOC     = 2'd1,
        ST_RESOLVED  = 2'd2,
        ST_COMMITTED = 2'd3
    } ent_state_e;

    ent_state_e             state_r [SB_ENTRY];
    ent_state_e             state_s [SB_ENTRY];
    logic [WORD_SIZE_P-1:0] addr_r  [SB_ENTRY];
    logic [WORD_SIZE_P-1:0] addr_s  [SB_ENTRY];
    logic [WORD_SIZE_P-1:0] data_r  [SB_ENTRY];
    logic [WORD_SIZE_P-1:0] data_s  [SB_ENTRY];
    logic [IW-1:0]          alloc_pt_r, commit_pt_r, drain_pt_r;
    logic [IW-1:0]          alloc_pt_s, commit_pt_s, drain_pt_s;
    logic [CW-1:0]          count_r, count_s, uncommit_cnt_s;
    logic                   alloc_fire_s, drain_fire_s, exe_ok_s, exe_wr_s;
    logic                   commit_legal_s, commit_fire_s, exe_bad_s, commit_bad_s;

    assign alloc_ready_o = (count_r != CW'(SB_ENTRY)) & ~rob_mispredict_i;
    assign alloc_idx_o   = alloc_pt_r;
    assign empty_o       = (count_r == {CW{1'b0}});
    assign mem_valid_o   = (state_r[drain_pt_r] == ST_COMMITTED);
    assign mem_addr_o    = mem_valid_o ? addr_r[drain_pt_r] : {WORD_SIZE_P{1'b0}};
    assign mem_data_o    = mem_valid_o ? data_r[drain_pt_r] : {WORD_SIZE_P{1'b0}};

    assign alloc_fire_s  = alloc_valid_i & alloc_ready_o;
    assign drain_fire_s  = mem_valid_o & mem_ready_i;
    assign exe_ok_s      = exe_valid_i & ((state_r[exe_idx_i] == ST_ALLOC) |
                                          (state_r[exe_idx_i] == ST_RESOLVED));
    assign exe_wr_s      = exe_ok_s & ~rob_mispredict_i;
    // A same-cycle resolve makes the commit of a still-ALLOC head entry legal.
    assign commit_legal_s = (state_r[commit_pt_r] == ST_RESOLVED) |
                            ((state_r[commit_pt_r] == ST_ALLOC) & exe_ok_s & (exe_idx_i == commit_pt_r));
    assign commit_fire_s = rob_sb_valid_i & commit_legal_s & ~rob_mispredict_i;
    assign exe_bad_s     = exe_valid_i & ~exe_ok_s & ~rob_mispredict_i;
    assign commit_bad_s  = rob_sb_valid_i & ~commit_legal_s & ~rob_mispredict_i;

    assign alloc_pt_s  = rob_mispredict_i ? commit_pt_r : alloc_pt_r + IW'(alloc_fire_s);
    assign commit_pt_s = commit_pt_r + IW'(commit_fire_s);
    assign drain_pt_s  = drain_pt_r + IW'(drain_fire_s);
    assign count_s     = count_r + CW'(alloc_fire_s) - CW'(drain_fire_s)
                         - (rob_mispredict_i ? uncommit_cnt_s : {CW{1'b0}});

    // Number of entries a flush would discard
    always_comb begin
        uncommit_cnt_s = {CW{1'b0}};
        for (int i = 0; i < SB_ENTRY; i++) begin
            if ((state_r[i] == ST_ALLOC) || (state_r[i] == ST_RESOLVED)) begin
                uncommit_cnt_s = uncommit_cnt_s + CW'(1'b1);
            end else begin
                uncommit_cnt_s = uncommit_cnt_s;
            end
        end
    end

    // Per-entry next state and payload; flush has top priority over the other events
    always_comb begin
        for (int i = 0; i < SB_ENTRY; i++) begin
            if (rob_mispredict_i && ((state_r[i] == ST_ALLOC) || (state_r[i] == ST_RESOLVED))) begin
                state_s[i] = ST_FREE;
            end else if (drain_fire_s && (IW'(i) == drain_pt_r)) begin
                state_s[i] = ST_FREE;
            end else if (commit_fire_s && (IW'(i) == commit_pt_r)) begin
                state_s[i] = ST_COMMITTED;
            end else if (alloc_fire_s && (IW'(i) == alloc_pt_r)) begin
                state_s[i] = ST_ALLOC;
            end else if (exe_wr_s && (IW'(i) == exe_idx_i)) begin
                state_s[i] = ST_RESOLVED;
            end else begin
                state_s[i] = state_r[i];
            end
            if (exe_wr_s && (IW'(i) == exe_idx_i)) begin
                addr_s[i] = exe_addr_i;
                data_s[i] = exe_data_i;
            end else begin
                addr_s[i] = addr_r[i];
                data_s[i] = data_r[i];
            end
        end
    end

    // State, payload, pointer and occupancy registers
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < SB_ENTRY; i++) begin
                state_r[i] <= ST_FREE;
                addr_r[i]  <= {WORD_SIZE_P{1'b0}};
                data_r[i]  <= {WORD_SIZE_P{1'b0}};
            end
            alloc_pt_r  <= {IW{1'b0}};
            commit_pt_r <= {IW{1'b0}};
            drain_pt_r  <= {IW{1'b0}};
            count_r     <= {CW{1'b0}};
        end else begin
            state_r     <= state_s;
            addr_r      <= addr_s;
            data_r      <= data_s;
            alloc_pt_r  <= alloc_pt_s;
            commit_pt_r <= commit_pt_s;
            drain_pt_r  <= drain_pt_s;
            count_r     <= count_s;
        end
    end

`ifdef SB_FWD_EN
    logic [IW-1:0] fwd_slot_s;

    // Walk oldest to youngest: the last matching store wins, and any ALLOC seen after it stalls
    always_comb begin
        fwd_hit_o   = 1'b0;
        fwd_data_o  = {WORD_SIZE_P{1'b0}};
        fwd_stall_o = 1'b0;
        fwd_slot_s  = {IW{1'b0}};
        for (int k = 0; k < SB_ENTRY; k++) begin
            fwd_slot_s = drain_pt_r + IW'(k);
            if (!ld_valid_i) begin
                fwd_hit_o = 1'b0;
            end else if (state_r[fwd_slot_s] == ST_ALLOC) begin
                fwd_stall_o = 1'b1;
            end else if (((state_r[fwd_slot_s] == ST_RESOLVED) || (state_r[fwd_slot_s] == ST_COMMITTED))
                         && (addr_r[fwd_slot_s] == ld_addr_i)) begin
                fwd_hit_o   = 1'b1;
                fwd_data_o  = data_r[fwd_slot_s];
                fwd_stall_o = 1'b0;
            end else begin
                fwd_hit_o = fwd_hit_o;
            end
        end
    end
`endif

    store_buffer_chk u_chk (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .exe_bad    (exe_bad_s),
        .commit_bad (commit_bad_s)
    );
endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (SB_ENTRY=8, WORD_SIZE_P=16).
module tb_store_buffer;
    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        alloc_valid_i = 1'b0;
    logic        alloc_ready_o;
    logic [2:0]  alloc_idx_o;
    logic        exe_valid_i = 1'b0;
    logic [2:0]  exe_idx_i = 3'd0;
    logic [15:0] exe_addr_i = 16'h0000;
    logic [15:0] exe_data_i = 16'h0000;
    logic        rob_sb_valid_i = 1'b0;
    logic        rob_mispredict_i = 1'b0;
    logic        mem_valid_o;
    logic [15:0] mem_addr_o;
    logic [15:0] mem_data_o;
    logic        mem_ready_i = 1'b0;
    logic        empty_o;
`ifdef SB_FWD_EN
    logic        ld_valid_i = 1'b0;
    logic [15:0] ld_addr_i = 16'h0000;
    logic        fwd_hit_o;
    logic [15:0] fwd_data_o;
    logic        fwd_stall_o;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk_i = ~clk_i;

    store_buffer #(.SB_ENTRY(8), .WORD_SIZE_P(16)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_idx_o(alloc_idx_o),
        .exe_valid_i(exe_valid_i), .exe_idx_i(exe_idx_i), .exe_addr_i(exe_addr_i), .exe_data_i(exe_data_i),
        .rob_sb_valid_i(rob_sb_valid_i), .rob_mispredict_i(rob_mispredict_i),
        .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_ready_i(mem_ready_i),
`ifdef SB_FWD_EN
        .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i), .fwd_hit_o(fwd_hit_o),
        .fwd_data_o(fwd_data_o), .fwd_stall_o(fwd_stall_o),
`endif
        .empty_o(empty_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        alloc_valid_i = 1'b0; exe_valid_i = 1'b0; exe_idx_i = 3'd0;
        exe_addr_i = 16'h0000; exe_data_i = 16'h0000;
        rob_sb_valid_i = 1'b0; rob_mispredict_i = 1'b0; mem_ready_i = 1'b0;
`ifdef SB_FWD_EN
        ld_valid_i = 1'b0; ld_addr_i = 16'h0000;
`endif
    endtask

    task automatic do_reset();
        idle();
        reset_n_i = 1'b0;
        tick(); tick();
        reset_n_i = 1'b1;
    endtask

    task automatic alloc_one();
        alloc_valid_i = 1'b1; tick(); alloc_valid_i = 1'b0;
    endtask

    task automatic exe_wr(input logic [2:0] idx, input logic [15:0] addr, input logic [15:0] data);
        exe_valid_i = 1'b1; exe_idx_i = idx; exe_addr_i = addr; exe_data_i = data;
        tick();
        exe_valid_i = 1'b0;
    endtask

    task automatic commit_one();
        rob_sb_valid_i = 1'b1; tick(); rob_sb_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset_n_i = 1'b0;
        tick(); tick();
        reset_n_i = 1'b1;
        #1;
        vec_cnt++; if (alloc_ready_o !== 1'b1) begin err_cnt++; $display("FAIL reset_ready: got %b want 1", alloc_ready_o); end
        vec_cnt++; if (alloc_idx_o !== 3'd0) begin err_cnt++; $display("FAIL reset_idx: got %0d want 0", alloc_idx_o); end
        vec_cnt++; if (mem_valid_o !== 1'b0) begin err_cnt++; $display("FAIL reset_mem_valid: got %b want 0", mem_valid_o); end
        vec_cnt++; if (mem_addr_o !== 16'h0000) begin err_cnt++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr_o); end
        vec_cnt++; if (mem_data_o !== 16'h0000) begin err_cnt++; $display("FAIL reset_mem_data: got %h want 0000", mem_data_o); end
        vec_cnt++; if (empty_o !== 1'b1) begin err_cnt++; $display("FAIL reset_empty: got %b want 1", empty_o); end
    endtask

    task automatic test_single();
        do_reset();
        alloc_valid_i = 1'b1; #1;
        vec_cnt++; if (alloc_idx_o !== 3'd0) begin err_cnt++; $display("FAIL single_idx: got %0d want 0", alloc_idx_o); end
        tick(); alloc_valid_i = 1'b0;
        exe_wr(3'd0, 16'h0040, 16'hBEEF);
        rob_sb_valid_i = 1'b1; #1;
        vec_cnt++; if (mem_valid_o !== 1'b0) begin err_cnt++; $display("FAIL single_precommit: got %b want 0", mem_valid_o); end
        tick(); rob_sb_valid_i = 1'b0; mem_ready_i = 1'b1; #1;
        vec_cnt++; if (mem_valid_o !== 1'b1) begin err_cnt++; $display("FAIL single_valid: got %b want 1", mem_valid_o); end
        vec_cnt++; if (mem_addr_o !== 16'h0040) begin err_cnt++; $display("FAIL single_addr: got %h want 0040", mem_addr_o); end
        vec_cnt++; if (mem_data_o !== 16'hBEEF) begin err_cnt++; $display("FAIL single_data: got %h want beef", mem_data_o); end
        vec_cnt++; if (empty_o !== 1'b0) begin err_cnt++; $display("FAIL single_notempty: got %b want 0", empty_o); end
        tick(); mem_ready_i = 1'b0; #1;
        vec_cnt++; if (mem_valid_o !== 1'b0) begin err_cnt++; $display("FAIL single_drained: got %b want 0", mem_valid_o); end
        vec_cnt++; if (empty_o !== 1'b1) begin err_cnt++; $display("FAIL single_empty: got %b want 1", empty_o); end
    endtask

    task automatic test_full();
        do_reset();
        alloc_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            vec_cnt++; if (alloc_idx_o !== 3'(i)) begin err_cnt++; $display("FAIL full_idx%0d: got %0d want %0d", i, alloc_idx_o, i); end
            tick();
        end
        #1;
        vec_cnt++; if (alloc_ready_o !== 1'b0) begin err_cnt++; $display("FAIL full_ready: got %b want 0", alloc_ready_o); end
        vec_cnt++; if (empty_o !== 1'b0) begin err_cnt++; $display("FAIL full_empty: got %b want 0", empty_o); end
        alloc_valid_i = 1'b0;
        exe_wr(3'd0, 16'h0500, 16'h0055);
        commit_one();
        mem_ready_i = 1'b1; #1;
        vec_cnt++; if (mem_valid_o !== 1'b1) begin err_cnt++; $display("FAIL full_drain_valid: got %b want 1", mem_valid_o); end
        vec_cnt++; if (alloc_ready_o !== 1'b0) begin err_cnt++; $display("FAIL full_no_bypass: got %b want 0", alloc_ready_o); end
        tick(); mem_ready_i = 1'b0; #1;
        vec_cnt++; if (alloc_ready_o !== 1'b1) begin err_cnt++; $display("FAIL full_ready_back: got %b want 1", alloc_ready_o); end
        vec_cnt++; if (alloc_idx_o !== 3'd0) begin err_cnt++; $display("FAIL full_wrap_idx: got %0d want 0", alloc_idx_o); end
    endtask

    task automatic test_backpressure();
        do_reset();
        alloc_one();
        exe_wr(3'd0, 16'h1234, 16'h5678);
        commit_one();
        mem_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            vec_cnt++; if (mem_valid_o !== 1'b1) begin err_cnt++; $display("FAIL bp_valid%0d: got %b want 1", c, mem_valid_o); end
            vec_cnt++; if (mem_addr_o !== 16'h1234) begin err_cnt++; $display("FAIL bp_addr%0d: got %h want 1234", c, mem_addr_o); end
            vec_cnt++; if (mem_data_o !== 16'h5678) begin err_cnt++; $display("FAIL bp_data%0d: got %h want 5678", c, mem_data_o); end
            tick();
        end
        mem_ready_i = 1'b1; #1;
        vec_cnt++; if (mem_valid_o !== 1'b1) begin err_cnt++; $display("FAIL bp_accept_valid: got %b want 1", mem_valid_o); end
        tick(); mem_ready_i = 1'b0; #1;
        vec_cnt++; if (mem_valid_o !== 1'b0) begin err_cnt++; $display("FAIL bp_done_valid: got %b want 0", mem_valid_o); end
        vec_cnt++; if (empty_o !== 1'b1) begin err_cnt++; $display("FAIL bp_done_empty: got %b want 1", empty_o); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) alloc_one();
        exe_wr(3'd0, 16'h0100, 16'hA0A0);
        exe_wr(3'd1, 16'h0104, 16'hB1B1);
        exe_wr(3'd2, 16'h0108, 16'hC2C2);
        commit_one();
        commit_one();
        rob_mispredict_i = 1'b1; alloc_valid_i = 1'b1;
        exe_valid_i = 1'b1; exe_idx_i = 3'd3; exe_addr_i = 16'h010C; exe_data_i = 16'hD3D3;
        #1;
        vec_cnt++; if (alloc_ready_o !== 1'b0) begin err_cnt++; $display("FAIL flush_ready: got %b want 0", alloc_ready_o); end
        tick(); idle(); #1;
        vec_cnt++; if (alloc_idx_o !== 3'd2) begin err_cnt++; $display("FAIL flush_alloc_pt: got %0d want 2", alloc_idx_o); end
        vec_cnt++; if (empty_o !== 1'b0) begin err_cnt++; $display("FAIL flush_notempty: got %b want 0", empty_o); end
        vec_cnt++; if (mem_valid_o !== 1'b1) begin err_cnt++; $display("FAIL flush_drain0_valid: got %b want 1", mem_valid_o); end
        vec_cnt++; if (mem_addr_o !== 16'h0100) begin err_cnt++; $display("FAIL flush_drain0_addr: got %h want 0100", mem_addr_o); end
        vec_cnt++; if (mem_data_o !== 16'hA0A0) begin err_cnt++; $display("FAIL flush_drain0_data: got %h want a0a0", mem_data_o); end
        mem_ready_i = 1'b1;
        tick();
        vec_cnt++; if (mem_valid_o !== 1'b1) begin err_cnt++; $display("FAIL flush_drain1_valid: got %b want 1", mem_valid_o); end
        vec_cnt++; if (mem_addr_o !== 16'h0104) begin err_cnt++; $display("FAIL flush_drain1_addr: got %h want 0104", mem_addr_o); end
        vec_cnt++; if (mem_data_o !== 16'hB1B1) begin err_cnt++; $display("FAIL flush_drain1_data: got %h want b1b1", mem_data_o); end
        tick(); mem_ready_i = 1'b0; #1;
        vec_cnt++; if (mem_valid_o !== 1'b0) begin err_cnt++; $display("FAIL flush_no_third: got %b want 0", mem_valid_o); end
        vec_cnt++; if (empty_o !== 1'b1) begin err_cnt++; $display("FAIL flush_count: got empty=%b want 1", empty_o); end
        alloc_valid_i = 1'b1; #1;
        vec_cnt++; if (alloc_idx_o !== 3'd2) begin err_cnt++; $display("FAIL flush_next_idx: got %0d want 2", alloc_idx_o); end
        tick(); alloc_valid_i = 1'b0; #1;
        vec_cnt++; if (empty_o !== 1'b0) begin err_cnt++; $display("FAIL flush_realloc: got empty=%b want 0", empty_o); end
        vec_cnt++; if (mem_valid_o !== 1'b0) begin err_cnt++; $display("FAIL flush_realloc_valid: got %b want 0", mem_valid_o); end
    endtask

    task automatic test_exe_commit_same();
        do_reset();
        alloc_one();
        exe_valid_i = 1'b1; exe_idx_i = 3'd0; exe_addr_i = 16'h0200; exe_data_i = 16'hCAFE;
        rob_sb_valid_i = 1'b1;
        tick(); idle(); mem_ready_i = 1'b1; #1;
        vec_cnt++; if (mem_valid_o !== 1'b1) begin err_cnt++; $display("FAIL same_valid: got %b want 1", mem_valid_o); end
        vec_cnt++; if (mem_addr_o !== 16'h0200) begin err_cnt++; $display("FAIL same_addr: got %h want 0200", mem_addr_o); end
        vec_cnt++; if (mem_data_o !== 16'hCAFE) begin err_cnt++; $display("FAIL same_data: got %h want cafe", mem_data_o); end
        tick(); mem_ready_i = 1'b0; #1;
        vec_cnt++; if (empty_o !== 1'b1) begin err_cnt++; $display("FAIL same_empty: got %b want 1", empty_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        alloc_one();
        exe_wr(3'd0, 16'h0010, 16'h0001);
        commit_one();
        alloc_valid_i = 1'b1; mem_ready_i = 1'b1; #1;
        vec_cnt++; if (alloc_idx_o !== 3'd1) begin err_cnt++; $display("FAIL b2b_idx: got %0d want 1", alloc_idx_o); end
        tick(); alloc_valid_i = 1'b0; mem_ready_i = 1'b0; #1;
        vec_cnt++; if (mem_valid_o !== 1'b0) begin err_cnt++; $display("FAIL b2b_valid: got %b want 0", mem_valid_o); end
        vec_cnt++; if (empty_o !== 1'b0) begin err_cnt++; $display("FAIL b2b_count: got empty=%b want 0", empty_o); end
        vec_cnt++; if (alloc_idx_o !== 3'd2) begin err_cnt++; $display("FAIL b2b_next_idx: got %0d want 2", alloc_idx_o); end
        exe_wr(3'd1, 16'h0012, 16'h0002);
        commit_one();
        mem_ready_i = 1'b1; #1;
        vec_cnt++; if (mem_addr_o !== 16'h0012) begin err_cnt++; $display("FAIL b2b_addr: got %h want 0012", mem_addr_o); end
        vec_cnt++; if (mem_data_o !== 16'h0002) begin err_cnt++; $display("FAIL b2b_data: got %h want 0002", mem_data_o); end
        tick(); mem_ready_i = 1'b0; #1;
        vec_cnt++; if (empty_o !== 1'b1) begin err_cnt++; $display("FAIL b2b_empty: got %b want 1", empty_o); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        alloc_one();
        exe_wr(3'd0, 16'h0300, 16'h3333);
        commit_one();
        #1;
        vec_cnt++; if (mem_valid_o !== 1'b1) begin err_cnt++; $display("FAIL midrst_pre: got %b want 1", mem_valid_o); end
        reset_n_i = 1'b0;
        tick(); reset_n_i = 1'b1; #1;
        vec_cnt++; if (mem_valid_o !== 1'b0) begin err_cnt++; $display("FAIL midrst_valid: got %b want 0", mem_valid_o); end
        vec_cnt++; if (empty_o !== 1'b1) begin err_cnt++; $display("FAIL midrst_empty: got %b want 1", empty_o); end
        vec_cnt++; if (alloc_idx_o !== 3'd0) begin err_cnt++; $display("FAIL midrst_idx: got %0d want 0", alloc_idx_o); end
    endtask

`ifdef SB_FWD_EN
    task automatic test_fwd();
        do_reset();
        alloc_one();
        alloc_one();
        exe_wr(3'd0, 16'h0010, 16'h1111);
        exe_wr(3'd1, 16'h0010, 16'h2222);
        ld_valid_i = 1'b1; ld_addr_i = 16'h0010; #1;
        vec_cnt++; if (fwd_hit_o !== 1'b1) begin err_cnt++; $display("FAIL fwd_hit: got %b want 1", fwd_hit_o); end
        vec_cnt++; if (fwd_data_o !== 16'h2222) begin err_cnt++; $display("FAIL fwd_data: got %h want 2222", fwd_data_o); end
        vec_cnt++; if (fwd_stall_o !== 1'b0) begin err_cnt++; $display("FAIL fwd_nostall: got %b want 0", fwd_stall_o); end
        ld_addr_i = 16'h0020; #1;
        vec_cnt++; if (fwd_hit_o !== 1'b0) begin err_cnt++; $display("FAIL fwd_miss: got %b want 0", fwd_hit_o); end
        alloc_one();
        ld_addr_i = 16'h0010; #1;
        vec_cnt++; if (fwd_hit_o !== 1'b1) begin err_cnt++; $display("FAIL fwd_hit2: got %b want 1", fwd_hit_o); end
        vec_cnt++; if (fwd_stall_o !== 1'b1) begin err_cnt++; $display("FAIL fwd_stall: got %b want 1", fwd_stall_o); end
        ld_valid_i = 1'b0; #1;
        vec_cnt++; if ({fwd_hit_o, fwd_stall_o, fwd_data_o} !== 18'h0) begin err_cnt++; $display("FAIL fwd_idle: got %b%b %h want 0", fwd_hit_o, fwd_stall_o, fwd_data_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_full();
        test_backpressure();
        test_flush();
        test_exe_commit_same();
        test_back_to_back();
        test_mid_reset();
`ifdef SB_FWD_EN
        test_fwd();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
In-order store buffer between execute and data memory, and the receiving end of the ROB commit-pop signal.
- Rename allocates one entry per store in program order.
- The execute unit fills in the address and data by index.
- Each ROB commit pulse marks the oldest uncommitted store as committed.
- Committed stores drain to data memory over a valid/ready handshake.
- A misprediction flush discards all uncommitted stores. Committed stores still drain.

Parameters:
SB_ENTRY, 8, number of entries; power of two, at least 2
WORD_SIZE_P, 16, address and data width

Ports:
clk_i  in  1  clock
reset_n_i  in  1  synchronous active-low reset
alloc_valid_i  in  1  rename presents a store for allocation
alloc_ready_o  out  1  free entry available
alloc_idx_o  out  $clog2(SB_ENTRY)  index assigned to the current allocation
exe_valid_i  in  1  execute writes a resolved store
exe_idx_i  in  $clog2(SB_ENTRY)  target entry
exe_addr_i  in  WORD_SIZE_P  store address
exe_data_i  in  WORD_SIZE_P  store data
rob_sb_valid_i  in  1  commit pulse: oldest uncommitted store commits
rob_mispredict_i  in  1  flush uncommitted entries
mem_valid_o  out  1  drain request
mem_addr_o  out  WORD_SIZE_P  drain address
mem_data_o  out  WORD_SIZE_P  drain data
mem_ready_i  in  1  memory accepts drain
empty_o  out  1  no valid entries

Behaviour:
- Interface: one clock, clk_i. Reset is synchronous and active-low, reset_n_i, sampled on the rising edge of clk_i.
- Per-entry state: FREE -> ALLOC (allocated) -> RESOLVED (exe write seen) -> COMMITTED -> FREE (drained).
- Pointers, each $clog2(SB_ENTRY) bits and wrapping modulo SB_ENTRY:
  - alloc_pt: next entry to allocate.
  - commit_pt: oldest uncommitted entry.
  - drain_pt: oldest valid entry.
- Occupancy count: $clog2(SB_ENTRY)+1 bits.
- Reset: all entries FREE, pointers 0, count 0. Outputs: alloc_ready_o=1, alloc_idx_o=0, mem_valid_o=0, mem_addr_o=0, mem_data_o=0, empty_o=1.
- alloc_ready_o = (count != SB_ENTRY) & ~rob_mispredict_i.
- alloc_idx_o = alloc_pt.
- Allocation fires on alloc_valid_i & alloc_ready_o. Entry becomes ALLOC, alloc_pt++, count++.
- Full: no bypass. A drain in the same cycle does not raise alloc_ready_o.
- Exe write: exe_valid_i writes addr/data into entry exe_idx_i and moves it ALLOC -> RESOLVED. A write to a FREE or COMMITTED entry is ignored and triggers a simulation assertion.
- Commit: rob_sb_valid_i moves entry commit_pt to COMMITTED and increments commit_pt.
  - An exe write to that same entry in the same cycle is accepted; the entry ends COMMITTED with the new addr/data.
  - Commit of an ALLOC entry with no same-cycle write, or commit while no uncommitted entry exists: assertion; state unchanged.
- Drain: mem_valid_o = (entry drain_pt is COMMITTED). mem_addr_o/mem_data_o come from that entry.
  - On mem_valid_o & mem_ready_i: entry FREE, drain_pt++, count--.
  - While mem_ready_i is low, the request stays asserted with addr/data held stable.
  - Drain latency: a commit in cycle N gives mem_valid_o in cycle N+1 when that entry is the head.
- Flush (rob_mispredict_i=1):
  - Next cycle, all entries from commit_pt up to alloc_pt are FREE; alloc_pt <= commit_pt; count <= number of COMMITTED entries.
  - Priority within the flush cycle: flush wins over alloc, commit and exe write. The drain handshake proceeds normally and its decrement is included.
- Simultaneous alloc + drain: count unchanged.
- empty_o = (count == 0).
- Mid-operation reset: every entry, committed ones included, is discarded; mem_valid_o drops next cycle.

Optional Feature:
- Macro: SB_FWD_EN.
- When defined, adds these ports:
  - ld_valid_i (in, 1)
  - ld_addr_i (in, WORD_SIZE_P)
  - fwd_hit_o (out, 1)
  - fwd_data_o (out, WORD_SIZE_P)
  - fwd_stall_o (out, 1)
- Forwarding is combinational, same cycle. Entries are searched youngest to oldest.
- The youngest RESOLVED or COMMITTED entry whose address matches ld_addr_i gives fwd_hit_o=1 and fwd_data_o = its data.
- fwd_stall_o=1 if any ALLOC entry is younger than the hit, or if there is no hit and any ALLOC entry exists (unknown address).
- All three outputs are 0 when ld_valid_i=0.
- When undefined: ports absent, no CAM logic.

Test Plan:
- Alloc 1 store (idx 0); exe write addr=0x0040 data=0xBEEF; commit pulse; mem_ready_i=1 -> mem_valid_o one cycle after commit with 0x0040/0xBEEF; empty_o=1 after the handshake.
- Alloc 8 stores -> alloc_ready_o=0 with count=8. Resolve, commit and drain one -> ready returns the next cycle, alloc_idx_o=0 (wrap).
- Hold mem_ready_i=0 for 5 cycles after commit -> mem_valid_o stays high with addr/data stable; accepted on the cycle mem_ready_i=1.
- 4 allocated, 2 committed, then rob_mispredict_i -> next cycle alloc_pt=2, count=2; both committed stores still drain in order; next alloc gets idx 2.
- Exe write and commit to the same entry in one cycle -> entry drains with the new data.
- SB_FWD_EN: stores to 0x10 (0x1111) then 0x10 (0x2222), both resolved; load 0x10 -> fwd_hit_o=1, fwd_data_o=0x2222. Add an ALLOC-only store -> fwd_stall_o=1.
